// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seq_mult_pkg;

  // FSM encoding: one bit is enough for the two states.
  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  // Iteration counter width. It needs enough bits to hold WIDTH itself,
  // because the counter increments once more on the final iteration.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier producing a full 2*WIDTH product, unsigned or two's-complement.
// Latency: WIDTH cycles from the accepting edge to the done pulse; one product per WIDTH+1 cycles back-to-back.
// Backpressure: start is ignored while busy; result is held until the next completion, no downstream stall.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]  mcand_q, mcand_d;
  logic [WIDTH:0]  mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   result_q, result_d;
  logic            done_q, done_d;

  // Operand magnitudes as captured on acceptance, and the final product
  // after optional sign restoration; both come from the generate block.
  logic [WIDTH:0]  a_mag, b_mag;
  logic [PW-1:0]   res_fin;

  logic            accept;
  logic [PW-1:0]   mcand_ext;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   acc_sum;

  assign accept    = (state_q == ST_IDLE) && start;
  // Magnitude is WIDTH+1 bits; zero-extend to the accumulator width.
  assign mcand_ext = {{(PW-WIDTH-1){1'b0}}, mcand_q};
  assign partial   = mcand_ext << cnt_q;
  assign acc_sum   = mplier_q[0] ? (acc_q + partial) : acc_q;

  generate
    if (SIGNED) begin : g_signed
      localparam logic [WIDTH:0] MAG_ONE = {{WIDTH{1'b0}}, 1'b1};
      localparam logic [PW-1:0]  ACC_ONE = {{(PW-1){1'b0}}, 1'b1};
      logic sign_q;

      // Sign-extend by one bit before negating so -2^(WIDTH-1) is exact.
      assign a_mag   = a[WIDTH-1] ? (~{1'b1, a} + MAG_ONE) : {1'b0, a};
      assign b_mag   = b[WIDTH-1] ? (~{1'b1, b} + MAG_ONE) : {1'b0, b};
      assign res_fin = sign_q ? (~acc_sum + ACC_ONE) : acc_sum;

      // Remember the product sign for the duration of the operation.
      always_ff @(posedge clk) begin
        if (rst) begin
          sign_q <= 1'b0;
        end else if (accept) begin
          sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
        end
      end
    end else begin : g_unsigned
      assign a_mag   = {1'b0, a};
      assign b_mag   = {1'b0, b};
      assign res_fin = acc_sum;
    end
  endgenerate

  // Next-state and datapath update for the IDLE/RUN control loop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          result_d = res_fin;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset clears everything and takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with a start/busy/done handshake; the next generation of the team's times-table multiplier. It accepts one operand pair per transaction, computes the full-width product over WIDTH clock cycles and holds the result until the next transaction completes. It supports unsigned or two's-complement operation. It sits between a control FSM or testbench driver and any consumer of arithmetic results.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..16.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and result.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when `busy`=0.
- a  in  WIDTH  multiplicand; captured on the accepting edge.
- b  in  WIDTH  multiplier; captured on the accepting edge.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse when `result` is updated.
- result  out  2*WIDTH  full product; holds its value between updates.

## Operation
- States: IDLE and RUN. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `result`=0. The internal accumulator, operand registers and bit counter are all cleared.
- IDLE:
  - If `start`=1 on an edge, capture `a` and `b` and clear the accumulator.
  - Load the counter with 0 and enter RUN.
  - With SIGNED=1, capture magnitudes |a| and |b|, and store sign = a[MSB] ^ b[MSB].
- RUN, each edge:
  - If the multiplier LSB = 1, add the multiplicand, shifted left by the counter value, into a 2*WIDTH accumulator.
  - Shift the multiplier right by one and increment the counter.
- After the WIDTH-th RUN edge:
  - Load `result` with the accumulator, or its two's-complement negation when sign = 1.
  - Pulse `done` and return to IDLE.
- Width rules:
  - The accumulator is 2*WIDTH bits.
  - Magnitudes are WIDTH+1 bits internally, so that |−2^(WIDTH−1)| is exact.
  - The product never overflows 2*WIDTH in either mode.
- Boundary conditions:
  - `start` while `busy`=1: ignored; the operation in flight is unaffected.
  - Changes on `a`/`b` during RUN have no effect.
  - Zero operand: the full WIDTH cycles still elapse and `result`=0.
  - `start` held high continuously: back-to-back transactions. Each new one is accepted on the edge after `done` is asserted.
  - `rst` during RUN aborts the operation: `busy`=0, `done`=0 and `result`=0 on the next edge, with no `done` pulse.
  - `rst` and `start` high on the same edge: reset wins.

## Timing
- Edge N, `start` sampled high with `busy`=0: `busy`=1 after N.
- Edges N+1 … N+WIDTH: iterations.
- After edge N+WIDTH:
  - `result` is valid and `done`=1 for exactly one cycle.
  - `busy`=0.
- Latency: WIDTH cycles from the accepting edge to `done`.
- Throughput: one product per WIDTH+1 cycles with `start` held high.
- `result` changes only on the edge that raises `done`, or on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `seq_mult_pkg` holds:
  - the state typedef (IDLE, RUN);
  - a function returning the counter width, $clog2(WIDTH)+1.
- The FSM and datapath live in one module. The shift-add loop is too small to justify a separate sub-module.
- The optional sign handling is isolated by a `generate if (SIGNED)` block in the same file.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → `busy`=0, `done`=0, `result`=0 throughout, and no transaction starts.
- Unsigned times table, WIDTH=3: sweep all 64 (a, b) pairs, 0..7 × 0..7.
  - Each `done` occurs exactly 3 cycles after acceptance.
  - `result`=a*b; for 7×7, `result`=49 (6'b110001).
- Signed, WIDTH=4:
  - (−8)×(−8) → 64.
  - (−8)×7 → −56 (8'hC8).
  - 5×(−3) → −15 (8'hF1).
  - 0×(−8) → 0.
- Handshake, WIDTH=8:
  - Start 200×150; pulse `start` with new operands 3×3 mid-RUN → ignored, and `result`=30000 at `done`.
  - `result` stays at 30000 for 20 idle cycles.
- Back-to-back, WIDTH=8: hold `start`=1 with operand pairs 255×255 then 1×1.
  - `done` pulses are 9 cycles apart.
  - Results are 65025, then 1.
- Reset mid-operation, WIDTH=8: assert `rst` on the 4th RUN cycle of 12×12 → no `done`, `result`=0.
  - A subsequent 12×12 then completes correctly with `result`=144.
